// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared widths, latency bounds and FSM state encoding for the LDPC link controller.
//   MSG_W  - message width carried through the encode/decode path
//   CODE_W - codeword width produced by the encoder
//   LAT_*  - legal range of the encode/decode latency parameter
//   state_e - controller FSM states
package ldpc_pkg;

    localparam int unsigned MSG_W   = 4;
    localparam int unsigned CODE_W  = 12;
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned LAT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ldpc_sat_cnt.sv
// ldpc_sat_cnt: width-parameterised counter that saturates at all-ones, with a synchronous clear.
//   clk, rst_n - clock and asynchronous active-low reset
//   clr_i      - zero the count on this edge (wins over inc_i)
//   inc_i      - add one on this edge unless already all-ones
//   cnt_o      - current count
module ldpc_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ldpc_link_ctrl.sv
// ldpc_link_ctrl: sends one message at a time through an external encoder/decoder pair and checks it.
//   clk, rst_n          - clock and asynchronous active-low reset
//   in_valid/in_ready   - message source handshake, in_msg is the message
//   enc_msg             - registered message feeding the encoder
//   dec_msg             - message recovered by the decoder, sampled LAT edges after acceptance
//   out_valid/out_ready - result handshake; out_msg is the recovered message, out_err flags a mismatch
//   clr_cnt             - synchronous clear of frm_cnt and err_cnt
//   frm_cnt, err_cnt    - saturating counts of completed frames and mismatching frames
//   busy                - high whenever a frame is in flight or awaiting hand-off
module ldpc_link_ctrl
    import ldpc_pkg::*;
#(
    parameter int unsigned LAT = 2,
    parameter int unsigned CW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] in_msg,
    output logic [MSG_W-1:0] enc_msg,
    input  logic [MSG_W-1:0] dec_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MSG_W-1:0] out_msg,
    output logic             out_err,
    input  logic             clr_cnt,
    output logic [CW-1:0]    frm_cnt,
    output logic [CW-1:0]    err_cnt,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [MSG_W-1:0] enc_q, enc_d;
    logic [MSG_W-1:0] sent_q, sent_d;
    logic [MSG_W-1:0] out_msg_q, out_msg_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             frm_inc;

    always_comb begin
        state_d     = state_q;
        enc_d       = enc_q;
        sent_d      = sent_q;
        out_msg_d   = out_msg_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        lat_d       = lat_q;
        case (state_q)
            IDLE: if (in_valid) begin
                enc_d   = in_msg;
                sent_d  = in_msg;
                // Loading LAT-1 and sampling on the zero edge puts the capture exactly LAT edges after acceptance.
                lat_d   = LAT_W'(LAT - 1);
                state_d = WAIT;
            end
            WAIT: if (lat_q == '0) begin
                out_msg_d   = dec_msg;
                out_err_d   = dec_msg != sent_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end else begin
                lat_d = lat_q - LAT_W'(1);
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            enc_q       <= '0;
            sent_q      <= '0;
            out_msg_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            enc_q       <= enc_d;
            sent_q      <= sent_d;
            out_msg_q   <= out_msg_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            lat_q       <= lat_d;
        end
    end

    // A frame counts only when the sink takes it, so abandoned frames never reach the counters.
    assign frm_inc = state_q == DONE && out_ready;

    ldpc_sat_cnt #(.W(CW)) u_frm_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(clr_cnt),
        .inc_i(frm_inc),
        .cnt_o(frm_cnt)
    );

    ldpc_sat_cnt #(.W(CW)) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(clr_cnt),
        .inc_i(frm_inc && out_err_q),
        .cnt_o(err_cnt)
    );

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign enc_msg   = enc_q;
    assign out_valid = out_valid_q;
    assign out_msg   = out_msg_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ldpc_link_ctrl.sv
// tb_ldpc_link_ctrl: self-checking bench for ldpc_link_ctrl with a loopback decoder model and a scoreboard.
module tb_ldpc_link_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready, clr_cnt;
    logic [3:0]  in_msg;
    logic        in_ready, out_valid, out_err, busy;
    logic [3:0]  enc_msg, dec_msg, out_msg;
    logic [15:0] frm_cnt, err_cnt;
    logic        in_ready4, out_valid4, out_err4, busy4;
    logic [3:0]  enc_msg4, dec_msg4, out_msg4, frm_cnt4, err_cnt4;
    logic [3:0]  mask = 4'h0;
    logic [3:0]  dec_pipe;
    logic [4:0]  sb[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    // Decoder model: one register stage so the recovered message is valid only LAT-1 edges after enc_msg changes.
    always_ff @(posedge clk) dec_pipe <= enc_msg;
    assign dec_msg  = dec_pipe ^ mask;
    assign dec_msg4 = enc_msg4 ^ 4'h1;

    ldpc_link_ctrl #(.LAT(LAT), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
        .enc_msg(enc_msg), .dec_msg(dec_msg), .out_valid(out_valid), .out_ready(out_ready),
        .out_msg(out_msg), .out_err(out_err), .clr_cnt(clr_cnt), .frm_cnt(frm_cnt),
        .err_cnt(err_cnt), .busy(busy)
    );

    ldpc_link_ctrl #(.LAT(LAT), .CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_msg(in_msg),
        .enc_msg(enc_msg4), .dec_msg(dec_msg4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_msg(out_msg4), .out_err(out_err4), .clr_cnt(clr_cnt), .frm_cnt(frm_cnt4),
        .err_cnt(err_cnt4), .busy(busy4)
    );

    task automatic clear_counters();
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    task automatic start_frame(input logic [3:0] m);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_wait in_ready=%b want 1", in_ready);
        end
        in_valid = 1'b1;
        in_msg   = m;
        sb.push_back({mask != 4'h0, m ^ mask});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_frame(input logic clr);
        int e = 0;
        logic [4:0] exp;
        do begin
            @(negedge clk);
            e++;
        end while (!out_valid && e < 20);
        total++;
        if (e != LAT || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL latency edges=%0d out_valid=%b want %0d/1", e, out_valid, LAT);
        end
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got out_msg=%h", out_msg);
        end else begin
            exp = sb.pop_front();
            if ({out_err, out_msg} !== exp) begin
                bad++;
                $display("FAIL result err/msg=%b/%h want %b/%h", out_err, out_msg, exp[4], exp[3:0]);
            end
        end
        out_ready = 1'b1;
        clr_cnt   = clr;
        @(negedge clk);
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL exit out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0; in_msg = 4'h0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({in_ready, busy, out_valid, out_err, enc_msg, out_msg} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0}) begin
            bad++;
            $display("FAIL reset rdy/busy/ov/err/enc/out=%b%b%b%b/%h/%h want 1000/0/0",
                     in_ready, busy, out_valid, out_err, enc_msg, out_msg);
        end
        total++;
        if (frm_cnt !== 16'h0 || err_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_cnt frm=%h err=%h want 0/0", frm_cnt, err_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        clear_counters();
        mask = 4'h0;
        start_frame(4'hA);
        finish_frame(1'b0);
        total++;
        if (frm_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL loop_cnt frm=%0d err=%0d want 1/0", frm_cnt, err_cnt);
        end
        total++;
        if (enc_msg !== 4'hA || busy !== 1'b0) begin
            bad++;
            $display("FAIL enc_hold enc=%h busy=%b want A/0", enc_msg, busy);
        end
    endtask

    task automatic test_error();
        clear_counters();
        mask = 4'h6;
        start_frame(4'h5);
        finish_frame(1'b0);
        mask = 4'h0;
        total++;
        if (frm_cnt !== 16'd1 || err_cnt !== 16'd1) begin
            bad++;
            $display("FAIL err_cnt frm=%0d err=%0d want 1/1", frm_cnt, err_cnt);
        end
    endtask

    task automatic test_hold();
        int e = 0;
        logic [4:0] exp;
        clear_counters();
        start_frame(4'hC);
        while (!out_valid && e < 20) begin
            @(negedge clk);
            e++;
        end
        exp = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_msg   = 4'h3;
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, busy, out_err, out_msg, enc_msg} !== {1'b1, 1'b0, 1'b1, exp[4], exp[3:0], 4'hC}) begin
                bad++;
                $display("FAIL hold[%0d] ov/rdy/busy/err=%b%b%b%b msg=%h enc=%h want 101%b %h C",
                         i, out_valid, in_ready, busy, out_err, out_msg, enc_msg, exp[4], exp[3:0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (frm_cnt !== 16'd1 || in_ready !== 1'b1 || enc_msg !== 4'hC) begin
            bad++;
            $display("FAIL hold_exit frm=%0d rdy=%b enc=%h want 1/1/C", frm_cnt, in_ready, enc_msg);
        end
    endtask

    task automatic test_saturate();
        clear_counters();
        mask = 4'h0;
        for (int i = 0; i < 20; i++) begin
            start_frame(4'(i));
            finish_frame(1'b0);
            if (i == 15) begin
                total++;
                if (frm_cnt4 !== 4'hF || err_cnt4 !== 4'hF) begin
                    bad++;
                    $display("FAIL sat16 frm4=%h err4=%h want F/F", frm_cnt4, err_cnt4);
                end
            end
        end
        total++;
        if (frm_cnt4 !== 4'hF || err_cnt4 !== 4'hF || frm_cnt !== 16'd20 || err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL sat20 frm4=%h err4=%h frm=%0d err=%0d want F/F/20/0", frm_cnt4, err_cnt4, frm_cnt, err_cnt);
        end
        start_frame(4'h7);
        finish_frame(1'b1);
        total++;
        if (frm_cnt4 !== 4'h0 || err_cnt4 !== 4'h0 || frm_cnt !== 16'd0) begin
            bad++;
            $display("FAIL clr_prio frm4=%h err4=%h frm=%0d want 0/0/0", frm_cnt4, err_cnt4, frm_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_counters();
        in_valid = 1'b1;
        in_msg   = 4'h9;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        total++;
        if ({in_ready, busy, out_valid, out_err, enc_msg, out_msg} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0}
            || frm_cnt !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset rdy/busy/ov/err=%b%b%b%b enc=%h out=%h frm=%0d want 1000/0/0/0",
                     in_ready, busy, out_valid, out_err, enc_msg, out_msg, frm_cnt);
        end
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_msg   = 4'hB;
        sb.push_back({1'b0, 4'hB});
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || enc_msg !== 4'hB) begin
            bad++;
            $display("FAIL post_reset_accept busy=%b enc=%h want 1/B", busy, enc_msg);
        end
        finish_frame(1'b0);
        total++;
        if (frm_cnt !== 16'd1) begin
            bad++;
            $display("FAIL mid_reset_cnt frm=%0d want 1", frm_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int last = 0;
        int cyc = 0;
        logic [4:0] exp;
        clear_counters();
        mask      = 4'h0;
        out_ready = 1'b1;
        while (got < 16 && cyc < 300) begin
            if (in_ready && sent < 16) begin
                in_valid = 1'b1;
                in_msg   = 4'(sent);
                sb.push_back({1'b0, 4'(sent)});
                sent++;
            end
            if (out_valid) begin
                exp = sb.pop_front();
                total++;
                if ({out_err, out_msg} !== exp || (got > 0 && cyc - last != LAT + 2)) begin
                    bad++;
                    $display("FAIL b2b[%0d] err/msg=%b/%h gap=%0d want %b/%h gap=%0d",
                             got, out_err, out_msg, cyc - last, exp[4], exp[3:0], LAT + 2);
                end
                last = cyc;
                got++;
            end
            if (got < 16) begin
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (got != 16 || frm_cnt !== 16'd16 || err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL b2b_cnt got=%0d frm=%0d err=%0d want 16/16/0", got, frm_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_error();
        test_hold();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
